// File: rtl/regfile_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the parametrised integer register file:
//   - scrub_state_t : scrub engine FSM states (ST_IDLE, ST_SCRUB)
//   - RF_*_DEF      : default width/port constants
//   - rf_rd_addr()  : extracts read-port address p from a packed address bus
// ----------------------------------------------------------------------------
package regfile_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SCRUB = 1'b1
    } scrub_state_t;

    localparam int RF_DATA_W_DEF = 32;
    localparam int RF_ADDR_W_DEF = 5;
    localparam int RF_NUM_RD_DEF = 2;

    // Widest packed read-address bus the helper accepts (4 ports x 16 bits).
    localparam int RF_RD_BUS_MAX = 64;

    // Returns the address of read port `port` from a packed bus in which each
    // port occupies `addr_w` bits starting at port*addr_w. Callers zero-extend
    // their bus to RF_RD_BUS_MAX bits and truncate the result to their width.
    function automatic int unsigned rf_rd_addr(
        input logic [RF_RD_BUS_MAX-1:0] bus,
        input int unsigned              port,
        input int unsigned              addr_w
    );
        logic [RF_RD_BUS_MAX-1:0] w_shifted;
        logic [RF_RD_BUS_MAX-1:0] w_mask;
        w_shifted = bus >> (port * addr_w);
        w_mask    = (RF_RD_BUS_MAX'(1) << addr_w) - RF_RD_BUS_MAX'(1);
        return 32'(w_shifted & w_mask);
    endfunction

endpackage : regfile_pkg

// File: rtl/regfile_scrub_fsm.sv
// ----------------------------------------------------------------------------
// regfile_scrub_fsm
// Sequential scrub engine: on a clr_req sampled in IDLE it walks every
// register address once (one per cycle, starting at 0) so the parent can
// zero the array. The last step pulses o_scrub_done and the FSM returns to
// IDLE with the counter wrapped back to 0.
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   synchronous active-low reset (aborts a running scrub)
//   i_clr_req    in   start request, only looked at in IDLE
//   o_clr_busy   out  high for the whole scrub (Moore)
//   o_scrub_we   out  write-zero strobe for o_scrub_addr
//   o_scrub_addr out  register being zeroed this cycle
//   o_scrub_done out  high on the final scrub cycle
// ----------------------------------------------------------------------------
module regfile_scrub_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr_req,
    output logic              o_clr_busy,
    output logic              o_scrub_we,
    output logic [ADDR_W-1:0] o_scrub_addr,
    output logic              o_scrub_done
);

    scrub_state_t      r_state;
    logic [ADDR_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (i_clr_req) begin
                        r_state <= ST_SCRUB;
                    end
                end
                ST_SCRUB: begin
                    // Counter wraps to 0 on the last step, so no explicit clear.
                    r_cnt <= r_cnt + ADDR_W'(1);
                    if (r_cnt == {ADDR_W{1'b1}}) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_clr_busy   = (r_state == ST_SCRUB);
    assign o_scrub_we   = (r_state == ST_SCRUB);
    assign o_scrub_addr = r_cnt;
    assign o_scrub_done = (r_state == ST_SCRUB) && (r_cnt == {ADDR_W{1'b1}});

endmodule : regfile_scrub_fsm

// File: rtl/regfile_scoreboard.sv
// ----------------------------------------------------------------------------
// regfile_scoreboard
// Parametrised integer register file with two write ports (A = writeback,
// B = late load return), a per-register pending-write (busy) scoreboard and
// a sequential scrub engine that zeroes the array on request.
//
// Build option: define RF_BYPASS_EN to add write-through bypass of same-cycle
// writes onto the read ports. Without it, reads show registered state only.
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   synchronous active-low reset
//   rd_addr   in   packed read addresses, port p at [p*ADDR_W +: ADDR_W]
//   rd_data   out  packed read data (combinational)
//   rd_busy   out  busy bit of each read address (combinational)
//   wr_en/wr_addr/wr_data  in  port A write (wins over port B on same addr)
//   ld_en/ld_addr/ld_data  in  port B write, also clears busy[ld_addr]
//   res_en/res_addr        in  reserve: set busy[res_addr]
//   flush     in   clear every busy bit
//   clr_req   in   start scrub (looked at only while idle)
//   clr_busy  out  high while the scrub runs
// ----------------------------------------------------------------------------
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W_DEF,
    parameter int ADDR_W   = RF_ADDR_W_DEF,
    parameter int NUM_RD   = RF_NUM_RD_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       ld_en,
    input  logic [ADDR_W-1:0]          ld_addr,
    input  logic [DATA_W-1:0]          ld_data,
    input  logic                       res_en,
    input  logic [ADDR_W-1:0]          res_addr,
    input  logic                       flush,
    input  logic                       clr_req,
    output logic                       clr_busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DATA_W-1:0] w_reg_next [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  w_busy_next;

    logic              w_clr_busy;
    logic              w_scrub_we;
    logic [ADDR_W-1:0] w_scrub_addr;
    logic              w_scrub_done;

    regfile_scrub_fsm #(
        .ADDR_W (ADDR_W)
    ) u_scrub (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clr_req    (clr_req),
        .o_clr_busy   (w_clr_busy),
        .o_scrub_we   (w_scrub_we),
        .o_scrub_addr (w_scrub_addr),
        .o_scrub_done (w_scrub_done)
    );

    assign clr_busy = w_clr_busy;

    // ------------------------------------------------------------------
    // Per-register next-state for data and busy bit.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : gen_reg
            // Register 0 is hard-wired to zero/not-busy when ZERO_REG is set.
            localparam bit WRITABLE = (ZERO_REG == 0) || (gi != 0);

            logic w_a_hit;
            logic w_b_hit;
            logic w_res_hit;
            logic w_scrub_hit;

            assign w_a_hit     = wr_en  && (wr_addr      == ADDR_W'(gi));
            assign w_b_hit     = ld_en  && (ld_addr      == ADDR_W'(gi));
            assign w_res_hit   = res_en && (res_addr     == ADDR_W'(gi));
            assign w_scrub_hit = w_scrub_we && (w_scrub_addr == ADDR_W'(gi));

            // While scrubbing, both write ports are ignored and only the
            // scrub strobe can modify the array. Port A beats port B.
            assign w_reg_next[gi] =
                !WRITABLE   ? '0 :
                w_scrub_we  ? (w_scrub_hit ? '0 : r_regs[gi]) :
                w_a_hit     ? wr_data :
                w_b_hit     ? ld_data :
                              r_regs[gi];

            // flush and scrub completion clear everything; otherwise a new
            // reservation beats a load return to the same register.
            assign w_busy_next[gi] =
                !WRITABLE                   ? 1'b0 :
                (flush || w_scrub_done)     ? 1'b0 :
                w_scrub_we                  ? r_busy[gi] :
                w_res_hit                   ? 1'b1 :
                w_b_hit                     ? 1'b0 :
                                              r_busy[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= w_reg_next[i];
            end
            r_busy <= w_busy_next;
        end
    end

    // ------------------------------------------------------------------
    // Read ports (combinational, zero latency).
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : gen_rd
            logic [ADDR_W-1:0] w_idx;

            assign w_idx = ADDR_W'(rf_rd_addr(RF_RD_BUS_MAX'(rd_addr), gi, ADDR_W));

`ifdef RF_BYPASS_EN
            logic w_byp_ok;
            logic w_byp_a;
            logic w_byp_b;
            logic w_byp_res;

            // No forwarding while scrubbing (writes are dropped) or onto a
            // hard-wired zero register.
            assign w_byp_ok  = !w_scrub_we && !((ZERO_REG != 0) && (w_idx == '0));
            assign w_byp_a   = w_byp_ok && wr_en  && (wr_addr  == w_idx);
            assign w_byp_b   = w_byp_ok && ld_en  && (ld_addr  == w_idx);
            assign w_byp_res = res_en && (res_addr == w_idx);

            assign rd_data[gi*DATA_W +: DATA_W] =
                w_byp_a ? wr_data :
                w_byp_b ? ld_data :
                          r_regs[w_idx];

            // A returning load resolves the hazard early unless the same
            // register is being re-reserved this cycle.
            assign rd_busy[gi] = (w_byp_b && !w_byp_res) ? 1'b0 : r_busy[w_idx];
`else
            assign rd_data[gi*DATA_W +: DATA_W] = r_regs[w_idx];
            assign rd_busy[gi]                  = r_busy[w_idx];
`endif
        end
    endgenerate

endmodule : regfile_scoreboard

// File: tb/tb_regfile_scoreboard.sv
// ----------------------------------------------------------------------------
// tb_regfile_scoreboard
// Self-checking bench for regfile_scoreboard (DATA_W=32, ADDR_W=5, NUM_RD=2,
// ZERO_REG=1). A vector table drives single-cycle write/scoreboard traffic and
// pushes the expected read-back to a queue; the read-back after the commit
// edge pops and compares. Hand-written sequences cover scrub and reset.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_regfile_scoreboard;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic              clk;
    logic              rst_n;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data;
    logic [NR-1:0]     rd_busy;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              ld_en;
    logic [AW-1:0]     ld_addr;
    logic [DW-1:0]     ld_data;
    logic              res_en;
    logic [AW-1:0]     res_addr;
    logic              flush;
    logic              clr_req;
    logic              clr_busy;

    regfile_scoreboard #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .NUM_RD   (NR),
        .ZERO_REG (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .res_en   (res_en),
        .res_addr (res_addr),
        .flush    (flush),
        .clr_req  (clr_req),
        .clr_busy (clr_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          wr_en;
        logic [AW-1:0] wr_addr;
        logic [DW-1:0] wr_data;
        logic          ld_en;
        logic [AW-1:0] ld_addr;
        logic [DW-1:0] ld_data;
        logic          res_en;
        logic [AW-1:0] res_addr;
        logic          flush;
        logic [AW-1:0] chk0;
        logic [DW-1:0] exp_d0;
        logic          exp_b0;
        logic [AW-1:0] chk1;
        logic [DW-1:0] exp_d1;
        logic          exp_b1;
    } vec_t;

    typedef struct {
        int            id;
        logic [DW-1:0] d0;
        logic          b0;
        logic [DW-1:0] d1;
        logic          b1;
    } exp_t;

    localparam int NVEC = 11;
    vec_t vecs [NVEC];
    exp_t exp_q [$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input int id, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s #%0d actual=%h required=%h", nm, id, act, req);
        end
    endtask

    function automatic vec_t mk(
        input logic we, input int wa, input logic [DW-1:0] wd,
        input logic le, input int la, input logic [DW-1:0] ldd,
        input logic re, input int ra, input logic fl,
        input int c0, input logic [DW-1:0] d0, input logic b0,
        input int c1, input logic [DW-1:0] d1, input logic b1);
        vec_t v;
        v.wr_en = we; v.wr_addr = AW'(wa); v.wr_data = wd;
        v.ld_en = le; v.ld_addr = AW'(la); v.ld_data = ldd;
        v.res_en = re; v.res_addr = AW'(ra); v.flush = fl;
        v.chk0 = AW'(c0); v.exp_d0 = d0; v.exp_b0 = b0;
        v.chk1 = AW'(c1); v.exp_d1 = d1; v.exp_b1 = b1;
        return v;
    endfunction

    task automatic idle_inputs();
        wr_en = 1'b0; ld_en = 1'b0; res_en = 1'b0; flush = 1'b0; clr_req = 1'b0;
    endtask

    task automatic do_write(input int a, input logic [DW-1:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic do_reserve(input int a);
        @(negedge clk);
        res_en = 1'b1; res_addr = AW'(a);
        @(posedge clk); #1;
        res_en = 1'b0;
    endtask

    // Reads both ports after setting addresses; returns via outputs.
    task automatic read2(input int a0, input int a1,
                         output logic [DW-1:0] d0, output logic b0,
                         output logic [DW-1:0] d1, output logic b1);
        rd_addr = {AW'(a1), AW'(a0)};
        #1;
        d0 = rd_data[DW-1:0];  b0 = rd_busy[0];
        d1 = rd_data[2*DW-1:DW]; b1 = rd_busy[1];
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d0, d1;
        logic          b0, b1;
        exp_t          e;
        int            n;

        vecs[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,      0, 0, 0,  5, 32'hDEADBEEF, 0,  0, 0, 0);
        vecs[1]  = mk(1, 0, 32'h1234,     0, 0, 0,      1, 0, 0,  0, 0, 0,             5, 32'hDEADBEEF, 0);
        vecs[2]  = mk(1, 7, 32'hA,        1, 7, 32'hB,  0, 0, 0,  7, 32'hA, 0,         0, 0, 0);
        vecs[3]  = mk(0, 0, 0,            0, 0, 0,      1, 9, 0,  9, 0, 1,             7, 32'hA, 0);
        vecs[4]  = mk(0, 0, 0,            1, 9, 32'h55, 1, 9, 0,  9, 32'h55, 1,        7, 32'hA, 0);
        vecs[5]  = mk(0, 0, 0,            1, 9, 32'h66, 0, 0, 0,  9, 32'h66, 0,        5, 32'hDEADBEEF, 0);
        vecs[6]  = mk(0, 0, 0,            0, 0, 0,      1, 3, 1,  3, 0, 0,             9, 32'h66, 0);
        vecs[7]  = mk(1, 10, 32'h1,       1, 11, 32'h2, 0, 0, 0,  10, 32'h1, 0,        11, 32'h2, 0);
        vecs[8]  = mk(1, 12, 32'h77,      0, 0, 0,      1, 12, 0, 12, 32'h77, 1,       10, 32'h1, 0);
        vecs[9]  = mk(1, 12, 32'h88,      0, 0, 0,      0, 0, 0,  12, 32'h88, 1,       11, 32'h2, 0);
        vecs[10] = mk(0, 0, 0,            0, 0, 0,      0, 0, 1,  12, 32'h88, 0,       3, 0, 0);

        rst_n = 1'b0; rd_addr = '0;
        wr_addr = '0; wr_data = '0; ld_addr = '0; ld_data = '0; res_addr = '0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;

        // Reset state.
        check("reset_clr_busy", 0, DW'(clr_busy), 0);
        for (int a = 0; a < 32; a++) begin
            read2(a, 31 - a, d0, b0, d1, b1);
            check("reset_data", a, d0, 0);
            check("reset_busy", a, DW'(b0), 0);
        end
        $display("txn reset: 32 addresses read back");
        @(negedge clk);
        rst_n = 1'b1;

        // Same-cycle visibility of a write (bypass only when enabled).
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd13; wr_data = 32'hCAFE;
        rd_addr = {5'd0, 5'd13};
        #1;
`ifdef RF_BYPASS_EN
        check("same_cycle_bypass", 13, rd_data[DW-1:0], 32'hCAFE);
`else
        check("same_cycle_no_bypass", 13, rd_data[DW-1:0], 32'h0);
`endif
        @(posedge clk); #1;
        wr_en = 1'b0;
        #1;
        check("after_commit", 13, rd_data[DW-1:0], 32'hCAFE);
        $display("txn same-cycle write addr 13 rd=%h", rd_data[DW-1:0]);

        // Table-driven vectors with a scoreboard queue.
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            wr_en = vecs[i].wr_en; wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
            ld_en = vecs[i].ld_en; ld_addr = vecs[i].ld_addr; ld_data = vecs[i].ld_data;
            res_en = vecs[i].res_en; res_addr = vecs[i].res_addr; flush = vecs[i].flush;
            rd_addr = {vecs[i].chk1, vecs[i].chk0};
            exp_q.push_back('{i, vecs[i].exp_d0, vecs[i].exp_b0, vecs[i].exp_d1, vecs[i].exp_b1});
            @(posedge clk); #1;
            idle_inputs();
            #1;
            e = exp_q.pop_front();
            check("vec_rd0_data", e.id, rd_data[DW-1:0], e.d0);
            check("vec_rd0_busy", e.id, DW'(rd_busy[0]), DW'(e.b0));
            check("vec_rd1_data", e.id, rd_data[2*DW-1:DW], e.d1);
            check("vec_rd1_busy", e.id, DW'(rd_busy[1]), DW'(e.b1));
            $display("txn vec %0d rd0=%h b0=%b rd1=%h b1=%b", i,
                     rd_data[DW-1:0], rd_busy[0], rd_data[2*DW-1:DW], rd_busy[1]);
        end

        // Fill 1..31 with their index, reserve a couple, then scrub.
        for (int a = 1; a < 32; a++) begin
            do_write(a, DW'(a));
        end
        do_reserve(20);
        do_reserve(21);
        read2(20, 31, d0, b0, d1, b1);
        check("fill_rd20", 20, d0, 32'd20);
        check("fill_busy20", 20, DW'(b0), 1);
        check("fill_rd31", 31, d1, 32'd31);

        @(negedge clk);
        clr_req = 1'b1;
        @(posedge clk); #1;
        clr_req = 1'b0;
        n = 0;
        while (clr_busy && n < 100) begin
            n++;
            if (n == 20) begin
                wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'hBAD;
                res_en = 1'b1; res_addr = 5'd5;
            end
            if (n == 21) begin
                wr_en = 1'b0; res_en = 1'b0;
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        check("scrub_len", 0, DW'(n), 32);
        $display("txn scrub: clr_busy high for %0d cycles", n);
        for (int a = 0; a < 32; a++) begin
            read2(a, 31 - a, d0, b0, d1, b1);
            check("scrub_data", a, d0, 0);
            check("scrub_busy", a, DW'(b0), 0);
        end

        // Reset in the middle of a scrub.
        do_write(30, 32'h30);
        do_reserve(29);
        @(negedge clk);
        clr_req = 1'b1;
        @(posedge clk); #1;
        clr_req = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midreset_clr_busy", 0, DW'(clr_busy), 0);
        read2(30, 29, d0, b0, d1, b1);
        check("midreset_rd30", 30, d0, 0);
        check("midreset_busy29", 29, DW'(b1), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midreset_idle", 0, DW'(clr_busy), 0);
        $display("txn reset mid-scrub: clr_busy=%b", clr_busy);

        // Fresh scrub must start from register 0.
        do_write(1, 32'h11);
        do_write(31, 32'h31);
        @(negedge clk);
        clr_req = 1'b1;
        @(posedge clk); #1;
        clr_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        read2(1, 31, d0, b0, d1, b1);
        check("restart_rd1", 1, d0, 0);
        check("restart_rd31", 31, d1, 32'h31);
        n = 0;
        while (clr_busy && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        check("restart_len", 0, DW'(n), 30);
        read2(31, 1, d0, b0, d1, b1);
        check("restart_final31", 31, d0, 0);
        $display("txn restart scrub: rd1 cleared early, remaining %0d cycles", n);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_regfile_scoreboard

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the pipeline's integer register file.
- Generalised in data width, depth and number of read ports.
- Adds a second (late load) write port, a per-register pending-write scoreboard, optional write-through bypass and a sequential scrub engine that zeroes the array on request.
- Sits between ID (reads, reservations) and MEM/WB (writes); clocked on the rising edge.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- NUM_RD, 2, number of independent read ports (1..4).
- ZERO_REG, 1, when 1 register 0 reads 0, ignores writes and is never busy.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port p at [p*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed read data, combinational.
- rd_busy  out  NUM_RD  scoreboard bit of each read address, combinational.
- wr_en  in  1  port A (WB) write enable.
- wr_addr  in  ADDR_W  port A address.
- wr_data  in  DATA_W  port A data.
- ld_en  in  1  port B (late load return) write enable.
- ld_addr  in  ADDR_W  port B address.
- ld_data  in  DATA_W  port B data.
- res_en  in  1  reserve: set busy bit of res_addr (load issued).
- res_addr  in  ADDR_W  register to reserve.
- flush  in  1  clear all busy bits (pipeline flush).
- clr_req  in  1  start scrub; sampled only in IDLE.
- clr_busy  out  1  high while scrub runs; pipeline must stall.

Behaviour:
- Reset (rst_n=0 at posedge):
  - all registers = 0, all busy bits = 0, FSM = IDLE, scrub counter = 0, clr_busy = 0.
  - Reset mid-scrub aborts the scrub immediately.
- Writes commit at posedge.
  - Both ports to the same address in the same cycle: port A wins; port B's data is discarded.
  - Different addresses: both commit.
- ZERO_REG=1: writes and reservations to address 0 are dropped; rd_data reads 0 and rd_busy reads 0 for address 0.
- Scoreboard, evaluated at posedge:
  - res_en sets busy[res_addr]; ld_en clears busy[ld_addr].
  - Same address in the same cycle: set wins, because it is a new reservation.
  - Port A writes do not change busy bits.
  - flush clears every bit and overrides res_en in the same cycle.
- Reads are combinational from the array; read latency is 0.
- FSM states are IDLE and SCRUB.
  - IDLE -> SCRUB when clr_req=1.
  - In SCRUB, each cycle writes 0 to reg[cnt] and increments cnt.
  - The cycle with cnt = 2**ADDR_W-1 writes the last register, clears all busy bits, resets cnt to 0 and returns to IDLE.
  - Total scrub length is 2**ADDR_W cycles.
  - clr_busy = 1 exactly during SCRUB, Moore output.
- During SCRUB:
  - wr_en, ld_en and res_en are ignored.
  - flush still clears busy bits.
  - clr_req is ignored; there is no re-trigger.
  - Reads return current array contents.
- cnt is ADDR_W bits wide and wraps naturally on the final step.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: write-through bypass.
  - If rd_addr matches an enabled same-cycle port A write, rd_data returns wr_data.
  - Otherwise, on a matching port B write, it returns ld_data.
  - Port A has priority over port B.
  - rd_busy for a matching ld_en address reads 0 unless res_en targets the same address that cycle.
  - Bypass is suppressed during SCRUB and for register 0 when ZERO_REG=1.
- Undefined: rd_data and rd_busy reflect registered state only; a write becomes visible the cycle after commit.

Decomposition:
- Package regfile_pkg holds:
  - the FSM state enum (ST_IDLE, ST_SCRUB);
  - default width constants;
  - a function unpacking an address slice from a packed read-address bus.
- Sub-module regfile_scrub_fsm holds state, counter and clr_busy, and outputs scrub_we, scrub_addr and scrub_done.
- The array, scoreboard and bypass logic remain in the top.

Test Plan:
- Reset, then wr_en with addr 5 and data 0xDEADBEEF.
  - Next cycle, rd_addr[0]=5 returns 0xDEADBEEF.
  - With RF_BYPASS_EN, the same cycle also returns 0xDEADBEEF.
- wr to addr 0 with 0x1234, plus res_en on addr 0 -> rd_data=0, rd_busy=0 (ZERO_REG=1).
- Same cycle: wr_en and ld_en both to addr 7, data 0xA and 0xB -> reg7 = 0xA.
- Scoreboard sequence:
  - res_en addr 9 -> busy=1.
  - Next cycle, res_en and ld_en both on addr 9 -> busy stays 1.
  - Next, ld_en alone -> busy=0.
  - Then res_en on 3 plus flush -> busy[3]=0.
- Fill regs 1..31 with their index, then pulse clr_req:
  - clr_busy is high for exactly 32 cycles;
  - a wr_en during that window is ignored;
  - afterwards all regs read 0 and all busy bits are 0.
- Start scrub, assert rst_n=0 at cycle 10 of the scrub -> next cycle clr_busy=0, all regs 0, FSM IDLE; a fresh clr_req restarts cnt from 0.
